// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arb_pick.sv
// Combinational winner picker: fixed (highest index) or
// round-robin starting at rr_ptr.
module arb_pick
  import mem_bus_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  input  logic          mode,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = '0;
    win   = '0;
    if (mode == ARB_RR) begin
      for (int k = 0; k < N; k++) begin
        cand = IW'((int'(rr_ptr) + k) % N);
        if (!found && req[cand]) begin
          found = 1'b1;
          idx   = cand;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) idx = IW'(i);
      end
    end
    if (|req) win[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_bus_arb.sv
// N-master arbiter serialising accesses onto one
// synchronous-read memory bus.
module mem_bus_arb
  import mem_bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int RR_MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_lock,
  input  logic [NUM_MASTERS*AW-1:0] m_a,
  input  logic [NUM_MASTERS-1:0]    m_r_nw,
  input  logic [NUM_MASTERS*DW-1:0] m_dout,
  output logic [NUM_MASTERS-1:0]    m_gnt,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [DW-1:0]             m_rdata,
  output logic [AW-1:0]             s_a,
  output logic                      s_wr,
  output logic [DW-1:0]             s_dout,
  input  logic [DW-1:0]             s_din
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  state_t        state, state_nx;
  logic [N-1:0]  gnt, gnt_nx;
  logic [N-1:0]  ack, ack_nx;
  logic [N-1:0]  pick_oh;
  logic [IW-1:0] pick_idx, sel;
  logic [IW-1:0] widx, widx_nx;
  logic [IW-1:0] rr_ptr, rr_nx;
  logic [AW-1:0] a_q, a_nx, sel_a;
  logic [DW-1:0] dout_q, dout_nx, sel_d;
  logic [DW-1:0] rdata_q, rdata_nx;
  logic          wr_q, wr_nx;
  logic          rd_q, rd_nx;
  logic          sel_rnw;

  arb_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (m_req),
    .rr_ptr (rr_ptr),
    .mode   (MODE),
    .win    (pick_oh),
    .idx    (pick_idx)
  );

  // Only the picker result (IDLE) or the current owner (RESP) is sampled.
  assign sel     = (state == ST_IDLE) ? pick_idx : widx;
  assign sel_a   = m_a[AW*sel +: AW];
  assign sel_d   = m_dout[DW*sel +: DW];
  assign sel_rnw = m_r_nw[sel];

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    ack_nx   = '0;
    widx_nx  = widx;
    rr_nx    = rr_ptr;
    a_nx     = a_q;
    dout_nx  = dout_q;
    wr_nx    = 1'b0;
    rd_nx    = rd_q;
    rdata_nx = '0;
    unique case (state)
      ST_IDLE: begin
        if (|m_req) begin
          gnt_nx   = pick_oh;
          widx_nx  = pick_idx;
          a_nx     = sel_a;
          dout_nx  = sel_d;
          wr_nx    = ~sel_rnw;
          rd_nx    = sel_rnw;
          rr_nx    = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
          state_nx = ST_ADDR;
        end else begin
          gnt_nx  = '0;
          a_nx    = '0;
          dout_nx = '0;
        end
      end
      ST_ADDR: state_nx = ST_DATA;
      ST_DATA: begin
        rdata_nx = rd_q ? s_din : '0;
        ack_nx   = gnt;
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (m_lock[widx] && m_req[widx]) begin
          a_nx     = sel_a;
          dout_nx  = sel_d;
          wr_nx    = ~sel_rnw;
          rd_nx    = sel_rnw;
          state_nx = ST_ADDR;
        end else begin
          gnt_nx   = '0;
          a_nx     = '0;
          dout_nx  = '0;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      ack     <= '0;
      widx    <= '0;
      rr_ptr  <= '0;
      a_q     <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nx;
      gnt     <= gnt_nx;
      ack     <= ack_nx;
      widx    <= widx_nx;
      rr_ptr  <= rr_nx;
      a_q     <= a_nx;
      dout_q  <= dout_nx;
      wr_q    <= wr_nx;
      rd_q    <= rd_nx;
      rdata_q <= rdata_nx;
    end
  end

  assign m_gnt   = gnt;
  assign m_ack   = ack;
  assign m_rdata = rdata_q;
  assign s_a     = a_q;
  assign s_wr    = wr_q;
  assign s_dout  = dout_q;

endmodule

// File: doc/mem_bus_arb.md
Name: mem_bus_arb

Overview:
- Parametrised N-master arbiter for one shared memory bus. It is the sequential successor to the static cpu/dbg address-data mux in front of cpumc/ppumc.
- It serialises requests from the CPU, debugger, DMA and similar masters onto a single synchronous-read memory controller.
- It registers the winning master's address, R/!W and write data onto the bus, and returns read data with a one-cycle ack.
- Supports fixed-priority and round-robin modes, plus a per-master bus lock for multi-access sequences such as a debugger break.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- AW, 16, address width.
- DW, 8, data width.
- RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous assert, active-low.
- m_req  in  NUM_MASTERS  per-master request; held until ack.
- m_lock  in  NUM_MASTERS  per-master lock request; sampled in RESP.
- m_a  in  NUM_MASTERS*AW  flattened addresses; master i occupies [i*AW +: AW].
- m_r_nw  in  NUM_MASTERS  per-master R/!W.
- m_dout  in  NUM_MASTERS*DW  flattened write data.
- m_gnt  out  NUM_MASTERS  one-hot grant, held ADDR..RESP.
- m_ack  out  NUM_MASTERS  one-hot, one-cycle completion pulse.
- m_rdata  out  DW  shared read data; valid only while any m_ack bit is high.
- s_a  out  AW  registered bus address.
- s_wr  out  1  write strobe.
- s_dout  out  DW  registered write data.
- s_din  in  DW  slave read data; externally OR-combined, unhit slaves drive 0.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE immediately.
  - m_gnt, m_ack, m_rdata, s_a, s_wr and s_dout clear to 0 immediately, so an in-flight write is never strobed.
  - rr_ptr clears to 0.
- States: IDLE -> ADDR -> DATA -> RESP -> IDLE (or -> ADDR when locked).
- IDLE:
  - If any m_req is high, pick a winner at the clock edge.
  - Register m_gnt, s_a and s_dout from the winner; set s_wr = ~m_r_nw[winner]; go to ADDR.
  - If no request is pending, stay in IDLE and drive all outputs 0.
- ADDR: bus is driven; s_wr is high for exactly this one cycle on writes. Go to DATA.
- DATA:
  - s_a is held and s_wr = 0. s_din is valid because memory read latency is 1.
  - At the edge, m_rdata is registered from s_din on reads, or 0 on writes.
  - Set m_ack[winner] and go to RESP.
- RESP:
  - m_ack and m_rdata are valid for this single cycle; m_gnt is still held.
  - If m_lock[winner] and m_req[winner] are both high, go directly to ADDR for the same master, re-registering its new s_a/s_dout/s_wr with no arbitration.
  - Otherwise clear m_gnt and go to IDLE.
- Latency and throughput:
  - m_req rising in IDLE gives ack 3 cycles later.
  - Unlocked: 4 cycles per access.
  - Locked back-to-back: 3 cycles per access.
- Master rule: deassert m_req, or present a new access, in the cycle after ack. If req is still high in IDLE, it is a new request.
- Fixed mode: the highest-index requesting master wins. The debugger is wired to index NUM_MASTERS-1.
- Round-robin mode:
  - Search starts at rr_ptr and wraps modulo NUM_MASTERS; the first requester found wins.
  - On each IDLE grant, rr_ptr = winner+1, wrapping to 0 at NUM_MASTERS.
  - Locked re-grants do not move rr_ptr.
- Simultaneous events:
  - A request arriving during ADDR/DATA/RESP waits for IDLE.
  - Requests from non-granted masters never affect the active transaction.
  - A lock asserted by a non-granted master has no effect.
- m_req dropping mid-transaction is a protocol violation. The transaction still completes and the ack is still issued.
- Only the granted master's inputs are sampled, and only in IDLE, or in RESP when locked.

Decomposition:
- Package mem_bus_arb_pkg:
  - State encoding constants ST_IDLE, ST_ADDR, ST_DATA, ST_RESP (2 bits).
  - Mode constants ARB_FIXED = 0, ARB_RR = 1.
- One sub-module, arb_pick: combinational picker.
  - Inputs: req vector, rr_ptr, mode.
  - Outputs: one-hot winner plus winner index.
  - Used by the FSM in IDLE only.

Test Plan:
- Single read, NUM_MASTERS=2:
  - Stimulus: m0 requests a=0x0123, r_nw=1; slave returns 0xA5.
  - Required: s_a=0x0123 from cycle 1; m_ack[0] and m_rdata=0xA5 in cycle 3; m_gnt=0 in cycle 4.
- Single write:
  - Stimulus: m1 writes a=0x2000, dout=0x3C.
  - Required: s_wr high for exactly 1 cycle (cycle 1) with s_a=0x2000 and s_dout=0x3C; m_ack[1] in cycle 3 with m_rdata=0x00.
- Fixed priority:
  - Stimulus: m0 and m1 request in the same cycle.
  - Required: m1 is granted first; m0 is acked 4 cycles after m1's ack.
- Round-robin, NUM_MASTERS=4, RR_MODE=1:
  - Stimulus: all four masters hold req continuously.
  - Required: grant order 0, 1, 2, 3, 0; each master receives exactly one ack per 16 cycles.
- Lock:
  - Stimulus: m1 holds m_lock and performs 3 reads at 0x0000/0x0001/0x0002 while m0 requests continuously.
  - Required: acks 3 cycles apart; m0 is not granted until m1's lock drops.
- Reset mid-write:
  - Stimulus: rst driven low asynchronously during ADDR of a write.
  - Required: s_wr, m_gnt and m_ack are 0 immediately with no clock edge; state IDLE after release; the next request completes normally.
